// File: rtl/sram_fifo.sv
// Show-ahead FIFO over a 1-write/1-read synchronous array with a registered head.
// Define SRAM_FIFO_ERR_EN to add the sticky error output.
module sram_fifo #(
   parameter int DEPTH                 = 8,
   parameter int DATA_WIDTH            = 32,
   parameter int ALMOST_FULL_THRESHOLD = DEPTH - 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     flush_en,
   input  logic                     enqueue_en,
   input  logic [DATA_WIDTH-1:0]    enqueue_value,
   input  logic                     dequeue_en,
   output logic [DATA_WIDTH-1:0]    dequeue_value,
   output logic                     empty,
   output logic                     full,
   output logic                     almost_full,
   output logic [$clog2(DEPTH):0]   count
`ifdef SRAM_FIFO_ERR_EN
   ,
   output logic                     error
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] head_p1;
   logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [AW-1:0]         wr_ptr_nxt, rd_ptr_nxt;
   logic [CW-1:0]         count_q, count_nxt;
   logic                  empty_q, full_q, afull_q;
   logic                  do_enq, do_deq;

   // A full FIFO only accepts a write when the same cycle pops an entry.
   assign do_deq = dequeue_en && !empty_q && !flush_en;
   assign do_enq = enqueue_en && (!full_q || dequeue_en) && !flush_en;

   always_comb begin
      wr_ptr_nxt = wr_ptr_q;
      rd_ptr_nxt = rd_ptr_q;
      count_nxt  = count_q;
      if (flush_en) begin
         wr_ptr_nxt = '0;
         rd_ptr_nxt = '0;
         count_nxt  = '0;
      end else begin
         if (do_enq) wr_ptr_nxt = wr_ptr_q + AW'(1);
         if (do_deq) rd_ptr_nxt = rd_ptr_q + AW'(1);
         if (do_enq && !do_deq)
            count_nxt = count_q + CW'(1);
         else if (do_deq && !do_enq)
            count_nxt = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_enq)
         mem[wr_ptr_q] <= enqueue_value;
   end

   // p0 -> p1: the array is read at the post-dequeue pointer, so the head
   // register always holds the entry that will be at the front next cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         head_p1 <= '0;
      else if (do_enq && (wr_ptr_q == rd_ptr_nxt))
         head_p1 <= enqueue_value;
      else
         head_p1 <= mem[rd_ptr_nxt];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         afull_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_nxt;
         rd_ptr_q <= rd_ptr_nxt;
         count_q  <= count_nxt;
         empty_q  <= (count_nxt == '0);
         full_q   <= (count_nxt == CW'(DEPTH));
         afull_q  <= (int'(count_nxt) >= ALMOST_FULL_THRESHOLD);
      end
   end

`ifdef SRAM_FIFO_ERR_EN
   logic err_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         err_q <= 1'b0;
      else if (flush_en)
         err_q <= 1'b0;
      else if ((enqueue_en && full_q && !dequeue_en) || (dequeue_en && empty_q))
         err_q <= 1'b1;
   end

   assign error = err_q;
`endif

   assign dequeue_value = head_p1;
   assign empty         = empty_q;
   assign full          = full_q;
   assign almost_full   = afull_q;
   assign count         = count_q;

endmodule

// File: tb/tb_sram_fifo.sv
// Bench for sram_fifo: directed and random steps checked against a queue model.
module tb_sram_fifo;

   localparam int DEPTH = 8;
   localparam int DW    = 32;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          flush_en;
   logic          enqueue_en;
   logic [DW-1:0] enqueue_value;
   logic          dequeue_en;
   logic [DW-1:0] dequeue_value;
   logic          empty;
   logic          full;
   logic          almost_full;
   logic [3:0]    count;

   int            errors = 0;
   int            checks = 0;
   logic [DW-1:0] model_q[$];

   sram_fifo #(
      .DEPTH(DEPTH),
      .DATA_WIDTH(DW)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .flush_en(flush_en),
      .enqueue_en(enqueue_en),
      .enqueue_value(enqueue_value),
      .dequeue_en(dequeue_en),
      .dequeue_value(dequeue_value),
      .empty(empty),
      .full(full),
      .almost_full(almost_full),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int n;
      n = model_q.size();
      chk({tag, ".count"}, 32'(count), 32'(n));
      chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
      chk({tag, ".full"}, 32'(full), 32'(n == DEPTH));
      chk({tag, ".almost_full"}, 32'(almost_full), 32'(n >= DEPTH - 2));
      if (n > 0)
         chk({tag, ".data"}, dequeue_value, model_q[0]);
   endtask

   // One clock: drive, apply the FIFO rules to the model at the edge, then check.
   task automatic step(input string tag, input logic e, input logic [DW-1:0] v,
                       input logic d, input logic f);
      bit deq_ok, enq_ok;
      enqueue_en    = e;
      enqueue_value = v;
      dequeue_en    = d;
      flush_en      = f;
      @(posedge clk);
      if (f) begin
         model_q.delete();
      end else begin
         deq_ok = d && (model_q.size() > 0);
         enq_ok = e && ((model_q.size() < DEPTH) || d);
         if (deq_ok) void'(model_q.pop_front());
         if (enq_ok) model_q.push_back(v);
      end
      #1;
      enqueue_en = 1'b0;
      dequeue_en = 1'b0;
      flush_en   = 1'b0;
      check_all(tag);
   endtask

   initial begin
      reset_n       = 1'b0;
      flush_en      = 1'b0;
      enqueue_en    = 1'b0;
      enqueue_value = '0;
      dequeue_en    = 1'b0;
      #12;
      check_all("reset");
      chk("reset.data", dequeue_value, 32'h0);
      reset_n = 1'b1;

      // Fill 0x11..0x18, then drain back-to-back.
      for (int i = 0; i < DEPTH; i++)
         step("fill", 1'b1, 32'h11 + 32'(i), 1'b0, 1'b0);
      chk("fill.head", dequeue_value, 32'h11);
      for (int i = 0; i < DEPTH; i++)
         step("drain", 1'b0, '0, 1'b1, 1'b0);
      step("deq_empty", 1'b0, '0, 1'b1, 1'b0);

      // Single-entry latency and simultaneous push/pop at count 1.
      step("lat_a5", 1'b1, 32'hA5, 1'b0, 1'b0);
      chk("lat_a5.value", dequeue_value, 32'hA5);
      step("lat_5a", 1'b1, 32'h5A, 1'b1, 1'b0);
      chk("lat_5a.value", dequeue_value, 32'h5A);
      step("lat_pop", 1'b0, '0, 1'b1, 1'b0);
      step("empty_both", 1'b1, 32'h77, 1'b1, 1'b0);
      step("empty_both_pop", 1'b0, '0, 1'b1, 1'b0);

      // Full with steady push/pop across several pointer wraps, then a dropped push.
      for (int i = 0; i < DEPTH; i++)
         step("fill2", 1'b1, $urandom, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++)
         step("full_both", 1'b1, $urandom, 1'b1, 1'b0);
      step("full_drop", 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
      for (int i = 0; i < DEPTH; i++)
         step("drain2", 1'b0, '0, 1'b1, 1'b0);

      // Flush wins over a same-cycle enqueue.
      for (int i = 0; i < 5; i++)
         step("fill5", 1'b1, $urandom, 1'b0, 1'b0);
      step("flush", 1'b1, 32'h1234, 1'b0, 1'b1);
      step("post_flush", 1'b1, 32'h0BAD_F00D, 1'b0, 1'b0);

      // Random traffic with occasional flushes.
      for (int i = 0; i < 400; i++)
         step("rand", ($urandom % 10) < 6, $urandom, ($urandom % 10) < 5,
              ($urandom % 40) == 0);

      // Reset pulsed mid-burst takes effect without a clock edge.
      for (int i = 0; i < 4; i++)
         step("burst", 1'b1, $urandom, 1'b0, 1'b0);
      enqueue_en    = 1'b1;
      enqueue_value = 32'hFFFF_0000;
      #2 reset_n = 1'b0;
      #1;
      model_q.delete();
      enqueue_en = 1'b0;
      check_all("async_rst");
      chk("async_rst.data", dequeue_value, 32'h0);
      #3 reset_n = 1'b1;
      step("first_after_rst", 1'b1, 32'hC3C3_0001, 1'b0, 1'b0);
      chk("first_after_rst.value", dequeue_value, 32'hC3C3_0001);
      step("pop_after_rst", 1'b0, '0, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sram_fifo.md
SRAM_FIFO -- requirements
Module: sram_fifo

Interface
REQ-001 Parameter DEPTH, default 8, number of entries; SHALL be a power of two, minimum 4.
REQ-002 Parameter DATA_WIDTH, default 32, bits per entry.
REQ-003 Parameter ALMOST_FULL_THRESHOLD, default DEPTH-2, count at or above which almost_full asserts.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 flush_en  input  1  discards all entries.
REQ-007 enqueue_en  input  1  pushes enqueue_value this cycle.
REQ-008 enqueue_value  input  DATA_WIDTH  data to push.
REQ-009 dequeue_en  input  1  pops the head entry this cycle.
REQ-010 dequeue_value  output  DATA_WIDTH  head entry, valid whenever empty=0 (show-ahead).
REQ-011 empty  output  1  no entries held.
REQ-012 full  output  1  count == DEPTH.
REQ-013 almost_full  output  1  count >= ALMOST_FULL_THRESHOLD.
REQ-014 count  output  $clog2(DEPTH)+1  entries held.

Function
REQ-015 Storage: internal 1-write/1-read synchronous array, one-cycle read latency, with write-to-read bypass on a same-address same-cycle write and read; no combinational array read.
REQ-016 Read/write pointers: $clog2(DEPTH) bits, wrapping from DEPTH-1 to 0 with no gap.
REQ-017 Head: holding register feeds dequeue_value; the block SHALL prefetch the next entry so that back-to-back dequeues sustain one entry per cycle.
REQ-018 Latency: an entry enqueued in cycle N SHALL appear on dequeue_value with empty=0 in cycle N+1 when the FIFO was empty.
REQ-019 Dequeue in cycle N SHALL present the next entry on dequeue_value in cycle N+1, or raise empty if none.
REQ-020 Enqueue while full and dequeue_en=0: entry dropped; state unchanged.
REQ-021 Dequeue while empty: ignored; state unchanged.
REQ-022 Enqueue and dequeue in the same cycle while full: both take effect; count stays DEPTH.
REQ-023 Enqueue and dequeue in the same cycle while empty: dequeue ignored; enqueue accepted; count becomes 1.
REQ-024 Enqueue and dequeue in the same cycle otherwise: count unchanged; FIFO order preserved.
REQ-025 flush_en: empty=1, count=0, pointers=0 in the next cycle; it overrides enqueue_en and dequeue_en in the same cycle.
REQ-026 count, empty, full and almost_full SHALL be registered and mutually consistent every cycle.

Reset
REQ-027 While reset_n=0: pointers=0, count=0, empty=1, full=0, almost_full=0, dequeue_value=0, head/prefetch valid flags cleared.
REQ-028 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge; array contents need not clear.
REQ-029 The first enqueue SHALL be accepted on the first rising edge after reset_n deasserts.

Configuration
REQ-030 Macro SRAM_FIFO_ERR_EN defined: adds output error (1 bit, sticky, reset 0, cleared by flush_en), set on enqueue-while-full (REQ-020) or dequeue-while-empty (REQ-021).
REQ-031 SRAM_FIFO_ERR_EN undefined: error port and logic are absent; all other behaviour is identical.

Verification
REQ-032 DEPTH=8: enqueue 0x11..0x18 over 8 cycles -> full=1, count=8, almost_full=1 from count=6, dequeue_value=0x11.
REQ-033 From that full state, dequeue 8 back-to-back cycles -> values 0x11..0x18 in order, one per cycle; empty=1 after the last.
REQ-034 Empty FIFO, enqueue 0xA5 at cycle N -> empty=0 and dequeue_value=0xA5 at N+1; a simultaneous enqueue 0x5A plus dequeue at N+1 -> 0x5A at N+2, count=1.
REQ-035 Fill to 8, then enqueue plus dequeue together for 20 cycles -> count stays 8, data order intact across pointer wrap; an extra enqueue with no dequeue is dropped (error=1 with SRAM_FIFO_ERR_EN).
REQ-036 Count=5, then flush_en with enqueue_en=1 -> count=0 and empty=1 next cycle; reset_n pulsed low mid-burst -> outputs at reset values immediately, and the first post-reset enqueue is read back correctly.
